// File: rtl/cache_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_control                                              |
// | Description : Sequencing FSM for a 2-way set-associative write-back L1   |
// |               cache. Resolves hits in zero wait states. On a miss it     |
// |               picks a victim way, writes it back if it is dirty, then    |
// |               fills the line from physical memory. An optional watchdog  |
// |               abandons a physical-memory transaction that never answers. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   mem_read, mem_write     CPU request, held until mem_resp
//   mem_resp                CPU request complete (1-cycle pulse)
//   tag0_hit, tag1_hit      raw tag compare per way (not qualified by valid)
//   valid0/1, dirty0/1      state bits of the addressed set, per way
//   lru_out                 LRU way of the addressed set (1 = way 1)
//   lru_load                update LRU of the addressed set
//   way_load[1:0]           per-way data+tag array load
//   valid_set, dirty_set    set valid/dirty of the way selected by way_load
//   dirty_clr               clear dirty of victim_way
//   victim_way              registered victim, steers the write-back muxes
//   data_src_sel            0 = CPU write data, 1 = pmem line fill
//   pmem_addr_sel           0 = CPU address, 1 = write-back address
//   pmem_read, pmem_write   physical memory request, held until pmem_resp
//   pmem_resp               physical memory transaction complete
//   busy                    FSM is not idle
//   timeout_err             1-cycle pulse when the watchdog expires
module cache_control #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic       tag0_hit,
  input  logic       tag1_hit,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       dirty0,
  input  logic       dirty1,
  input  logic       lru_out,
  output logic       lru_load,
  output logic [1:0] way_load,
  output logic       valid_set,
  output logic       dirty_set,
  output logic       dirty_clr,
  output logic       victim_way,
  output logic       data_src_sel,
  output logic       pmem_addr_sel,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  output logic       busy,
  output logic       timeout_err
);

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int              c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              c_WDOG_EN  = (TIMEOUT != 0);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_victim;
  logic [c_CW-1:0] r_count;

  logic w_req;
  logic w_hit0;
  logic w_hit1;
  logic w_hit;
  logic w_victim;
  logic w_victim_dirty;
  logic w_expire;

  // The datapath's tag compare is raw, so qualify it with valid here.
  // Way 0 wins when both ways report a hit.
  assign w_req  = mem_read | mem_write;
  assign w_hit0 = tag0_hit & valid0;
  assign w_hit1 = tag1_hit & valid1 & ~w_hit0;
  assign w_hit  = w_hit0 | w_hit1;

  // Prefer an empty way over evicting; fall back to LRU when the set is full.
  assign w_victim       = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru_out);
  assign w_victim_dirty = w_victim ? (valid1 & dirty1) : (valid0 & dirty0);

  assign w_expire = c_WDOG_EN && (r_count == c_CNT_LAST) && !pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_victim <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req && !w_hit) begin
        r_victim <= w_victim;
      end
      // Restart the watchdog on every state change so each pmem
      // transaction gets its own budget.
      if (r_state == ST_IDLE || w_next != r_state) begin
        r_count <= '0;
      end else if (c_WDOG_EN && !pmem_resp) begin
        r_count <= r_count + c_CW'(1);
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    mem_resp      = 1'b0;
    lru_load      = 1'b0;
    way_load      = 2'b00;
    valid_set     = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;
    data_src_sel  = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    busy          = 1'b0;
    timeout_err   = 1'b0;
    victim_way    = r_victim;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            mem_resp = 1'b1;
            lru_load = 1'b1;
            // A simultaneous read+write is treated as a write.
            if (mem_write) begin
              way_load  = w_hit0 ? 2'b01 : 2'b10;
              dirty_set = 1'b1;
            end
          end else begin
            w_next = w_victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end

      ST_WRITEBACK: begin
        busy          = 1'b1;
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          dirty_clr = 1'b1;
          // A request withdrawn during write-back skips the fill.
          w_next    = w_req ? ST_ALLOCATE : ST_IDLE;
        end else if (w_expire) begin
          timeout_err = 1'b1;
          w_next      = ST_IDLE;
        end
      end

      ST_ALLOCATE: begin
        busy         = 1'b1;
        pmem_read    = 1'b1;
        data_src_sel = 1'b1;
        if (pmem_resp) begin
          way_load  = r_victim ? 2'b10 : 2'b01;
          valid_set = 1'b1;
          w_next    = ST_IDLE;
        end else if (w_expire) begin
          timeout_err = 1'b1;
          w_next      = ST_IDLE;
        end
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Nothing may leak out while reset is held, even with a request pending.
    if (!reset_n) begin
      mem_resp      = 1'b0;
      lru_load      = 1'b0;
      way_load      = 2'b00;
      valid_set     = 1'b0;
      dirty_set     = 1'b0;
      dirty_clr     = 1'b0;
      data_src_sel  = 1'b0;
      pmem_addr_sel = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      busy          = 1'b0;
      timeout_err   = 1'b0;
      victim_way    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cache_control                                           |
// | Description : Scoreboard bench for cache_control. Emulates a one-set     |
// |               datapath and a physical memory with random latency, and    |
// |               predicts each CPU request outcome from a transaction-level |
// |               2-way write-back cache model.                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_cache_control;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_read, mem_write, mem_resp;
  logic       tag0_hit, tag1_hit, valid0, valid1, dirty0, dirty1, lru_out;
  logic       lru_load;
  logic [1:0] way_load;
  logic       valid_set, dirty_set, dirty_clr, victim_way;
  logic       data_src_sel, pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
  logic       busy, timeout_err;

  always #5 clk = ~clk;

  cache_control #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .tag0_hit(tag0_hit), .tag1_hit(tag1_hit),
    .valid0(valid0), .valid1(valid1), .dirty0(dirty0), .dirty1(dirty1),
    .lru_out(lru_out), .lru_load(lru_load), .way_load(way_load),
    .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .victim_way(victim_way), .data_src_sel(data_src_sel),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Emulated datapath: one set, updated only by the DUT's strobes.
  logic [3:0] env_tag [2];
  logic [1:0] env_valid, env_dirty;
  logic       env_lru;
  logic [3:0] cur_tag;

  assign tag0_hit = (env_tag[0] == cur_tag);
  assign tag1_hit = (env_tag[1] == cur_tag);
  assign valid0   = env_valid[0];
  assign valid1   = env_valid[1];
  assign dirty0   = env_dirty[0];
  assign dirty1   = env_dirty[1];
  assign lru_out  = env_lru;

  // Reference cache state, advanced one whole transaction at a time.
  logic [3:0] ref_tag [2];
  logic [1:0] ref_valid, ref_dirty;
  logic       ref_lru;

  typedef struct {
    bit         hit;
    bit         wb;
    logic [3:0] wb_tag;
    logic [1:0] fill_wl;
    logic [1:0] resp_wl;
    bit         wr;
    logic [1:0] valid;
    logic [1:0] dirty;
    bit         lru;
    logic [3:0] tag0;
    logic [3:0] tag1;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int lat_sum  = 0;
  bit resp_en  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Physical memory: random 1..TIMEOUT cycle latency, pulse on the last cycle.
  initial begin : g_pmem
    bit r_active;
    int r_cnt, r_lat;
    r_active  = 1'b0;
    r_cnt     = 0;
    r_lat     = 1;
    pmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset_n && resp_en && (pmem_read || pmem_write)) begin
        if (!r_active) begin
          r_active = 1'b1;
          r_cnt    = 1;
          r_lat    = $urandom_range(1, TIMEOUT);
          lat_sum  = lat_sum + r_lat;
        end else begin
          r_cnt++;
        end
        pmem_resp = (r_cnt == r_lat);
        if (pmem_resp) r_active = 1'b0;
      end else begin
        pmem_resp = 1'b0;
        r_active  = 1'b0;
      end
    end
  end

  // Monitor: observes each transaction, pops the scoreboard on mem_resp,
  // then applies the DUT's array strobes to the emulated datapath.
  initial begin : g_monitor
    exp_t       e;
    int         m_cyc;
    int         m_wb;
    logic [3:0] m_wb_tag;
    logic [1:0] m_fill_wl;
    bit         got;
    bit         h0;
    m_cyc = 0; m_wb = 0; m_wb_tag = '0; m_fill_wl = '0;
    forever begin
      @(negedge clk);
      got = 1'b0;
      if (reset_n) begin
        if (pmem_write && pmem_resp) begin
          m_wb++;
          m_wb_tag = env_tag[victim_way];
          check("wb_addr_sel", pmem_addr_sel, 1);
        end
        if (pmem_read && pmem_resp) begin
          m_fill_wl = way_load;
          check("fill_valid_set", valid_set, 1);
          check("fill_src_sel", {data_src_sel, pmem_addr_sel}, 2'b10);
        end
        if (mem_resp) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got mem_resp=1 expected no response at %0t", $time);
          end else begin
            got = 1'b1;
            e   = sb.pop_front();
            check("latency", m_cyc, e.hit ? 0 : lat_sum + 1);
            check("wb_count", m_wb, e.wb ? 1 : 0);
            if (e.wb) check("wb_tag", m_wb_tag, e.wb_tag);
            check("fill_way_load", m_fill_wl, e.fill_wl);
            check("resp_way_load", way_load, e.resp_wl);
            check("resp_dirty_set", dirty_set, e.wr);
            check("resp_lru_busy", {lru_load, busy}, 2'b10);
          end
        end
        // Apply array strobes exactly as the datapath would on this edge.
        h0 = tag0_hit && valid0;
        for (int w = 0; w < 2; w++) begin
          if (way_load[w]) begin
            env_tag[w] = cur_tag;
            if (valid_set) env_valid[w] = 1'b1;
            if (dirty_set) env_dirty[w] = 1'b1;
          end
        end
        if (dirty_clr) env_dirty[victim_way] = 1'b0;
        if (lru_load)  env_lru = h0 ? 1'b1 : 1'b0;
        if (got) begin
          check("post_valid", env_valid, e.valid);
          check("post_dirty", env_dirty & env_valid, e.dirty & e.valid);
          check("post_lru", env_lru, e.lru);
          if (e.valid[0]) check("post_tag0", env_tag[0], e.tag0);
          if (e.valid[1]) check("post_tag1", env_tag[1], e.tag1);
        end
        if (mem_resp || !(mem_read || mem_write)) begin
          m_cyc = 0; m_wb = 0; m_fill_wl = '0; lat_sum = 0;
        end else begin
          m_cyc++;
        end
      end else begin
        m_cyc = 0; m_wb = 0; m_fill_wl = '0; lat_sum = 0;
      end
    end
  end

  task automatic preload(input logic [3:0] t0, input logic [3:0] t1,
                         input logic [1:0] v, input logic [1:0] d, input logic l);
    env_tag[0] = t0; env_tag[1] = t1; env_valid = v; env_dirty = d; env_lru = l;
    ref_tag[0] = t0; ref_tag[1] = t1; ref_valid = v; ref_dirty = d; ref_lru = l;
  endtask

  // Issue one CPU request (called just after a rising edge) and wait for it.
  task automatic do_req(input logic [3:0] tag, input bit wr, input bit rd);
    exp_t e;
    bit   way;
    bit   done;
    e = '{default: '0};
    if (ref_valid[0] && ref_tag[0] == tag) begin
      e.hit = 1'b1; way = 1'b0;
    end else if (ref_valid[1] && ref_tag[1] == tag) begin
      e.hit = 1'b1; way = 1'b1;
    end else begin
      way       = !ref_valid[0] ? 1'b0 : (!ref_valid[1] ? 1'b1 : ref_lru);
      e.wb      = ref_valid[way] && ref_dirty[way];
      e.wb_tag  = ref_tag[way];
      e.fill_wl = way ? 2'b10 : 2'b01;
      ref_tag[way]   = tag;
      ref_valid[way] = 1'b1;
      ref_dirty[way] = 1'b0;
    end
    if (wr) ref_dirty[way] = 1'b1;
    ref_lru   = ~way;
    e.wr      = wr;
    e.resp_wl = wr ? (way ? 2'b10 : 2'b01) : 2'b00;
    e.valid   = ref_valid;
    e.dirty   = ref_dirty;
    e.lru     = ref_lru;
    e.tag0    = ref_tag[0];
    e.tag1    = ref_tag[1];
    sb.push_back(e);

    cur_tag   = tag;
    mem_write = wr;
    mem_read  = rd | ~wr;
    done      = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_resp) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL req_wait: got no mem_resp expected one within 60 cycles (tag %0h)", tag);
      void'(sb.pop_back());
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if ($urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : g_stim
    logic [13:0] outs;
    mem_read = 1'b0; mem_write = 1'b0; cur_tag = '0;
    preload(4'h0, 4'h0, 2'b00, 2'b00, 1'b0);

    // Reset: a raw hit with a pending read must not leak through.
    reset_n  = 1'b0;
    env_valid = 2'b01;
    mem_read = 1'b1;
    #3;
    outs = {mem_resp, lru_load, way_load, valid_set, dirty_set, dirty_clr, victim_way,
            data_src_sel, pmem_addr_sel, pmem_read, pmem_write, busy, timeout_err};
    check("reset_outputs", outs, 14'h0);
    repeat (2) @(posedge clk);
    #1;
    mem_read = 1'b0;
    env_valid = 2'b00;
    reset_n  = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, victim_way, mem_resp, pmem_read, pmem_write}, 5'b0);
    @(posedge clk);
    #1;

    // Read hit in way 1.
    preload(4'h0, 4'h9, 2'b10, 2'b00, 1'b0);
    do_req(4'h9, 1'b0, 1'b1);

    // Write miss with both ways invalid, then the completing write hit.
    preload(4'h0, 4'h0, 2'b00, 2'b00, 1'b0);
    do_req(4'h5, 1'b1, 1'b0);

    // Read miss, full set, LRU way 1 dirty: write-back then fill way 1.
    preload(4'h1, 4'h2, 2'b11, 2'b10, 1'b1);
    do_req(4'h4, 1'b0, 1'b1);

    // Both ways claim the tag: way 0 takes the write (read+write = write).
    preload(4'h7, 4'h7, 2'b11, 2'b00, 1'b0);
    do_req(4'h7, 1'b1, 1'b1);

    // Watchdog: memory never answers a clean fill.
    preload(4'h0, 4'h0, 2'b00, 2'b00, 1'b0);
    resp_en  = 1'b0;
    cur_tag  = 4'h3;
    mem_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("to_miss_cycle_busy", busy, 0);
      end else begin
        check("to_pmem_read", pmem_read, 1);
        check("to_err", timeout_err, (k == 4) ? 1 : 0);
        check("to_no_load", {way_load, valid_set}, 3'b0);
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("to_back_idle", {busy, pmem_read, timeout_err}, 3'b0);
    check("to_arrays_untouched", env_valid, 2'b00);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a fill.
    cur_tag  = 4'h3;
    mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ar_in_allocate", {pmem_read, busy}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_drop_no_edge", {pmem_read, busy}, 2'b00);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    check("ar_idle", {busy, victim_way, env_valid}, 4'b0);
    @(posedge clk);
    #1;

    // Random traffic over a small tag space to mix hits, clean and dirty misses.
    preload(4'h0, 4'h0, 2'b00, 2'b00, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [3:0] t;
      bit         w;
      t = 4'($urandom_range(0, 5));
      w = 1'($urandom_range(0, 1));
      do_req(t, w, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
